// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with a one-byte holding register and valid/ready output.
// Frame and overrun errors are reported as single-cycle pulses.
module uart_byte_receiver #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          sample_pt;
  logic          byte_done;
  logic          stop_bad;

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], uart_rx};
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // IDLE is only entered with the line high, so a low level there is a falling edge.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!rx_s) state_nxt = S_START;
      S_START: if (sample_pt) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (sample_pt && (bit_cnt == 3'd7)) state_nxt = S_STOP;
      S_STOP:  if (sample_pt) state_nxt = rx_s ? S_IDLE : S_BRK;
      S_BRK:   if (rx_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    sample_pt = 1'b0;
    case (state)
      S_START:        sample_pt = (cnt == HALF_LAST);
      S_DATA, S_STOP: sample_pt = (cnt == FULL_LAST);
      default:        sample_pt = 1'b0;
    endcase
  end

  assign byte_done = (state == S_STOP) && sample_pt && rx_s;
  assign stop_bad  = (state == S_STOP) && sample_pt && !rx_s;

  // The sample counter restarts at every sample point and idles at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      if ((state == S_IDLE) || (state == S_BRK) || sample_pt) cnt <= '0;
      else                                                    cnt <= cnt + 1'b1;
      if (state == S_IDLE) bit_cnt <= 3'd0;
      else if ((state == S_DATA) && sample_pt) bit_cnt <= bit_cnt + 3'd1;
      if ((state == S_DATA) && sample_pt) shift_q <= {rx_s, shift_q[7:1]};
    end
  end

  // Handshake: a byte moves out on any cycle with rx_valid=1 and rx_ready=1;
  // rx_valid/rx_data hold until then, and a completion in that same cycle reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      frame_error   <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      frame_error   <= stop_bad;
      overrun_error <= 1'b0;
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_q;
          rx_valid <= 1'b1;
        end else begin
          overrun_error <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at 16 clocks per bit: a table of
// frames plus hand-written sequences for glitch, break, overrun and reset cases.
module tb_uart_byte_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_error;
  logic       overrun_error;
  logic       busy;

  uart_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rx       (uart_rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .frame_error   (frame_error),
    .overrun_error (overrun_error),
    .busy          (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / counters ----------------
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q[$];
  int unsigned rise_q[$];
  int          hs_cnt, ferr_cnt, ovr_cnt, busy_cnt;
  logic        prev_valid = 1'b0;
  logic        prev_ferr  = 1'b0;
  logic        prev_ovr   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    hs_cnt   = 0;
    ferr_cnt = 0;
    ovr_cnt  = 0;
    busy_cnt = 0;
    rise_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && !prev_valid) rise_q.push_back(cyc);
      if (rx_valid && rx_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got byte %0h, expected none", rx_data);
        end else begin
          check("sb_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (frame_error) begin
        ferr_cnt++;
        check("ferr_width", {31'h0, prev_ferr}, 32'h0);
      end
      if (overrun_error) begin
        ovr_cnt++;
        check("ovr_width", {31'h0, prev_ovr}, 32'h0);
      end
      if (busy) busy_cnt++;
    end
    prev_valid = rx_valid;
    prev_ferr  = frame_error;
    prev_ovr   = overrun_error;
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    idle(CPB);
  endtask

  // Leaves the line at the stop-bit level; caller raises it if needed.
  task automatic send_byte(input logic [7:0] d, input logic stop, output int unsigned start_cyc);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  vec_t        vecs[6];
  int unsigned s0, s1;

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};
    vecs[2] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h5A, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[5] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};

    rst      = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b1;
    clear_counts();
    repeat (3) @(negedge clk);
    check("reset_outputs", {19'h0, rx_data, rx_valid, frame_error, overrun_error, busy}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(5);

    // Table of single frames, consumer always ready.
    for (int i = 0; i < 6; i++) begin
      clear_counts();
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
      send_byte(vecs[i].data, vecs[i].stop, s0);
      uart_rx = 1'b1;
      idle(20);
      check($sformatf("vec%0d_valid_cycles", i), hs_cnt, {31'h0, vecs[i].exp_valid});
      check($sformatf("vec%0d_ferr", i), ferr_cnt, {31'h0, vecs[i].exp_ferr});
      check($sformatf("vec%0d_ovr", i), ovr_cnt, 32'h0);
      check($sformatf("vec%0d_busy_end", i), {31'h0, busy}, 32'h0);
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_latency", i), (rise_q.size() > 0) ? rise_q[0] - s0 : 32'hFFFF_FFFF, 155);
    end

    // Short glitch: start detected then rejected at the half-bit sample.
    clear_counts();
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(20);
    check("glitch_busy_cycles", busy_cnt, 8);
    check("glitch_valid", rise_q.size(), 0);
    check("glitch_errors", ferr_cnt + ovr_cnt, 0);

    // Bad stop bit followed by a long low line, then a good frame.
    clear_counts();
    send_byte(8'h3C, 1'b0, s0);
    idle(40);
    check("break_busy_low_line", {31'h0, busy}, 32'h1);
    uart_rx = 1'b1;
    idle(5);
    check("break_busy_released", {31'h0, busy}, 32'h0);
    check("break_ferr", ferr_cnt, 1);
    check("break_no_valid", rise_q.size(), 0);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, s0);
    idle(20);
    check("after_break_hs", hs_cnt, 1);

    // Overrun: second byte dropped while first is unconsumed.
    clear_counts();
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1, s0);
    idle(5);
    send_byte(8'h22, 1'b1, s0);
    idle(5);
    check("ovr_pulse", ovr_cnt, 1);
    check("ovr_valid_held", {31'h0, rx_valid}, 32'h1);
    check("ovr_data_held", {24'h0, rx_data}, 32'h11);
    check("ovr_single_rise", rise_q.size(), 1);
    rx_ready = 1'b1;
    idle(1);
    check("ovr_valid_cleared", {31'h0, rx_valid}, 32'h0);
    check("ovr_hs", hs_cnt, 1);

    // Completion in the very cycle the held byte is accepted.
    clear_counts();
    rx_ready = 1'b0;
    exp_q.push_back(8'h33);
    send_byte(8'h33, 1'b1, s0);
    idle(5);
    exp_q.push_back(8'h44);
    fork
      send_byte(8'h44, 1'b1, s1);
      begin
        idle(154);
        rx_ready = 1'b1;
      end
    join
    idle(5);
    check("same_cycle_ovr", ovr_cnt, 0);
    check("same_cycle_hs", hs_cnt, 2);
    check("same_cycle_valid_end", {31'h0, rx_valid}, 32'h0);

    // Reset in the middle of a frame.
    clear_counts();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rst     = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {19'h0, rx_data, rx_valid, frame_error, overrun_error, busy}, 32'h0);
    idle(3);
    rst = 1'b0;
    idle(5);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1, s0);
    idle(20);
    check("midreset_next_hs", hs_cnt, 1);
    check("midreset_errors", ferr_cnt + ovr_cnt, 0);

    // Back-to-back frames with no idle gap.
    clear_counts();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1, s0);
    send_byte(8'hFF, 1'b1, s1);
    idle(20);
    check("b2b_rises", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      check("b2b_first_latency", rise_q[0] - s0, 155);
      check("b2b_spacing", rise_q[1] - rise_q[0], 160);
    end
    check("b2b_errors", ferr_cnt + ovr_cnt, 0);

    check("sb_all_consumed", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_receiver.md
UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud); legal range 8..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic is rising-edge triggered on this single clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port rx_data  output  8  received byte, valid while rx_valid=1.
REQ-006 SHALL have port rx_valid  output  1  holding register contains an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts rx_data on a cycle with rx_valid=1 and rx_ready=1.
REQ-008 SHALL have port frame_error  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 SHALL have port overrun_error  output  1  one-cycle pulse when a completed byte is dropped because the holding register is full.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass uart_rx through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE -> START on a synchronized high-to-low transition; the bit counter is cleared.
REQ-014 START: sample at CLKS_PER_BIT/2 (integer division) cycles after the edge; low -> DATA; high -> IDLE (glitch rejected, no output, no error).
REQ-015 DATA: sample each bit every CLKS_PER_BIT cycles after the start-bit sample; shift LSB first; -> STOP after 8 samples.
REQ-016 STOP: sample CLKS_PER_BIT cycles after bit 7; high -> byte complete, -> IDLE; low -> frame_error pulse, byte discarded, -> BREAK.
REQ-017 BREAK: remain until the synchronized line is high, then -> IDLE; no start detection while in BREAK.
REQ-018 On byte completion: rx_valid=1 and rx_data=byte on the cycle after the stop sample.
REQ-019 rx_valid and rx_data SHALL be held stable until a cycle with rx_ready=1; rx_valid then clears on the next cycle unless a new byte is loaded in the same cycle.
REQ-020 Completion with rx_valid=1 and rx_ready=0: new byte dropped, overrun_error pulses 1 cycle, rx_data keeps the old byte.
REQ-021 Completion in the same cycle as acceptance (rx_valid=1, rx_ready=1): old byte consumed, new byte loaded, rx_valid stays 1, no overrun.
REQ-022 The sample counter SHALL wrap to 0 at each sample point; it is sized to hold CLKS_PER_BIT-1.
REQ-023 frame_error and overrun_error SHALL never stay high longer than 1 cycle; both may pulse in the same cycle as rx_valid changes.

Reset
REQ-024 While rst=1: FSM=IDLE, counters=0, rx_data=8'h00, rx_valid=0, frame_error=0, overrun_error=0, busy=0, synchronizer flops=1 (idle line, no false start on release).
REQ-025 Asserting rst mid-frame SHALL discard the partial byte immediately; after release the next valid frame SHALL be received correctly.

Verification (bench uses CLKS_PER_BIT=16)
REQ-026 Send 0xA5 with rx_ready=1 -> rx_valid=1 for exactly 1 cycle with rx_data=0xA5, 2+8+16*9+1 cycles after the start edge; no errors.
REQ-027 Drive uart_rx low for 4 cycles, then high -> busy rises, then returns to 0 at the start-bit sample point; rx_valid, frame_error and overrun_error stay 0.
REQ-028 Send 0x3C with stop bit 0, hold the line low for 40 cycles, then high -> one frame_error pulse, no rx_valid, busy=1 until the line is high, then 0x55 is received correctly.
REQ-029 Send 0x11 then 0x22 with rx_ready=0 -> rx_valid=1 with rx_data=0x11 throughout, one overrun_error pulse at 0x22 completion; rx_ready=1 then yields 0x11 and rx_valid clears.
REQ-030 Assert rst after 4 data bits of 0xFF -> all outputs 0 during reset; next frame 0x5A yields rx_data=0x5A and no errors.
REQ-031 Send back-to-back 0x00 and 0xFF (no idle gap) with rx_ready=1 -> two rx_valid pulses carrying 0x00 then 0xFF, 160 cycles apart; no errors.
